// File: rtl/debounce_filter_if.sv
// Switch-side signal bundle for debounce_filter: raw pin level in, filtered level and strobes out.
interface debounce_filter_if;
  logic i_Bouncy;
  logic o_Debounced;
  logic o_Rise;
  logic o_Fall;

  modport master (
    output i_Bouncy,
    input  o_Debounced,
    input  o_Rise,
    input  o_Fall
  );

  modport slave (
    input  i_Bouncy,
    output o_Debounced,
    output o_Rise,
    output o_Fall
  );
endinterface

// File: rtl/debounce_filter.sv
// Switch debouncer: optional synchronizer chain, then a counter that must see DEBOUNCE_LIMIT
// consecutive differing samples before the registered level flips and a rise/fall strobe fires.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 20,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  debounce_filter_if.slave sw
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic s_p0;

  // Stage 0: synchronizer (bypassed entirely when SYNC_STAGES is 0)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_p0 = sw.i_Bouncy;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_p0;
      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          sync_p0 <= '0;
        end else begin
          sync_p0[0] <= sw.i_Bouncy;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p0[i] <= sync_p0[i-1];
          end
        end
      end
      assign s_p0 = sync_p0[SYNC_STAGES-1];
    end
  endgenerate

  logic [CNT_W-1:0] count_p1;
  logic             deb_p1;
  logic             rise_p1;
  logic             fall_p1;

  // Stage 1: qualification counter and registered level/strobes
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_p1 <= '0;
      deb_p1   <= 1'b0;
      rise_p1  <= 1'b0;
      fall_p1  <= 1'b0;
    end else begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
      if (s_p0 == deb_p1) begin
        count_p1 <= '0;
      end else if (count_p1 == CNT_MAX) begin
        deb_p1   <= s_p0;
        count_p1 <= '0;
        rise_p1  <= s_p0;
        fall_p1  <= ~s_p0;
      end else begin
        count_p1 <= count_p1 + 1'b1;
      end
    end
  end

  assign sw.o_Debounced = deb_p1;
  assign sw.o_Rise      = rise_p1;
  assign sw.o_Fall      = fall_p1;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: three configurations share one stimulus stream and are checked
// every cycle against a "last N samples all differ" reference model, plus directed expectations.
module tb_debounce_filter;

  logic clk = 1'b0;
  logic rst;
  logic bouncy;

  always #5 clk = ~clk;

  debounce_filter_if ifa ();
  debounce_filter_if ifb ();
  debounce_filter_if ifc ();

  assign ifa.i_Bouncy = bouncy;
  assign ifb.i_Bouncy = bouncy;
  assign ifc.i_Bouncy = bouncy;

  debounce_filter #(.DEBOUNCE_LIMIT(4), .SYNC_STAGES(0)) u_a (.i_Clk(clk), .i_Reset(rst), .sw(ifa));
  debounce_filter #(.DEBOUNCE_LIMIT(1), .SYNC_STAGES(0)) u_b (.i_Clk(clk), .i_Reset(rst), .sw(ifb));
  debounce_filter #(.DEBOUNCE_LIMIT(4), .SYNC_STAGES(2)) u_c (.i_Clk(clk), .i_Reset(rst), .sw(ifc));

  int lim [3] = '{4, 1, 4};
  int stg [3] = '{0, 0, 2};

  bit b_log [0:2047];
  bit r_log [0:2047];
  int e = 0;

  // Samples seen since the last reset or output flip, per configuration
  bit hist [3][0:2047];
  int n    [3];
  bit m_deb  [3];
  bit m_rise [3];
  bit m_fall [3];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Value the filter sees at edge e: the pin level K edges ago, or 0 if a reset flushed it since.
  function automatic bit model_s(int c);
    for (int k = 1; k <= stg[c]; k++) begin
      if (e - k < 0) return 1'b0;
      if (r_log[e-k]) return 1'b0;
    end
    return b_log[e - stg[c]];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (r_log[e]) begin
        m_deb[c] = 1'b0;
        n[c]     = 0;
      end else begin
        bit s;
        bit all_diff;
        s = model_s(c);
        hist[c][n[c]] = s;
        n[c]++;
        if (n[c] >= lim[c]) begin
          all_diff = 1'b1;
          for (int j = n[c] - lim[c]; j < n[c]; j++)
            if (hist[c][j] == m_deb[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_deb[c]  = ~m_deb[c];
            m_rise[c] = m_deb[c];
            m_fall[c] = ~m_deb[c];
            n[c]      = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input bit b, input bit r);
    bouncy = b;
    rst    = r;
    @(posedge clk);
    b_log[e] = b;
    r_log[e] = r;
    model_edge();
    #1;
    check("a_deb",  ifa.o_Debounced, m_deb[0]);
    check("a_rise", ifa.o_Rise,      m_rise[0]);
    check("a_fall", ifa.o_Fall,      m_fall[0]);
    check("b_deb",  ifb.o_Debounced, m_deb[1]);
    check("b_rise", ifb.o_Rise,      m_rise[1]);
    check("b_fall", ifb.o_Fall,      m_fall[1]);
    check("c_deb",  ifc.o_Debounced, m_deb[2]);
    check("c_rise", ifc.o_Rise,      m_rise[2]);
    check("c_fall", ifc.o_Fall,      m_fall[2]);
    e++;
  endtask

  initial begin
    bit lvl;
    bit val;

    for (int c = 0; c < 3; c++) begin
      n[c] = 0; m_deb[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
    end

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_a_deb",  ifa.o_Debounced, 1'b0);
    check("rst_a_rise", ifa.o_Rise,      1'b0);
    check("rst_c_deb",  ifc.o_Debounced, 1'b0);
    check("rst_b_fall", ifb.o_Fall,      1'b0);

    // Glitch at edge 4, stable high from edge 6
    for (int ed = 1; ed <= 12; ed++) begin
      step(bit'(ed == 4 || ed >= 6), 1'b0);
      if (ed == 8)  check("glitch_a_deb8",  ifa.o_Debounced, 1'b0);
      if (ed == 9)  check("glitch_a_deb9",  ifa.o_Debounced, 1'b1);
      if (ed == 9)  check("glitch_a_rise9", ifa.o_Rise,      1'b1);
      if (ed == 10) check("glitch_a_rise10", ifa.o_Rise,     1'b0);
      if (ed == 10) check("sync2_c_deb10",  ifc.o_Debounced, 1'b0);
      if (ed == 11) check("sync2_c_deb11",  ifc.o_Debounced, 1'b1);
      if (ed == 11) check("sync2_c_rise11", ifc.o_Rise,      1'b1);
      if (ed == 12) check("sync2_c_rise12", ifc.o_Rise,      1'b0);
    end

    // Falling qualification: 0 x3, 1 x1, then steady 0
    for (int f = 1; f <= 12; f++) begin
      step(bit'(f == 4), 1'b0);
      if (f == 3) check("fall_a_deb3", ifa.o_Debounced, 1'b1);
      if (f == 7) check("fall_a_deb7", ifa.o_Debounced, 1'b1);
      if (f == 8) check("fall_a_deb8", ifa.o_Debounced, 1'b0);
      if (f == 8) check("fall_a_fall8", ifa.o_Fall,     1'b1);
      if (f == 9) check("fall_a_fall9", ifa.o_Fall,     1'b0);
    end

    // Reset mid-count with the input held high
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_a_deb",  ifa.o_Debounced, 1'b0);
    check("midrst_a_rise", ifa.o_Rise,      1'b0);
    check("midrst_a_fall", ifa.o_Fall,      1'b0);
    check("midrst_b_deb",  ifb.o_Debounced, 1'b0);
    for (int r = 1; r <= 4; r++) begin
      step(1'b1, 1'b0);
      if (r == 1) check("rstexit_b_rise", ifb.o_Rise,     1'b1);
      if (r == 3) check("rstexit_a_deb3", ifa.o_Debounced, 1'b0);
      if (r == 4) check("rstexit_a_deb4", ifa.o_Debounced, 1'b1);
      if (r == 4) check("rstexit_a_rise4", ifa.o_Rise,     1'b1);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);

    // Toggle every cycle: the LIMIT=1 instance follows with alternating strobes
    val = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step(val, 1'b0);
      check("lim1_deb",  ifb.o_Debounced, val);
      check("lim1_rise", ifb.o_Rise,      val);
      check("lim1_fall", ifb.o_Fall,      ~val);
      val = ~val;
    end
    lvl = ~val;
    for (int k = 0; k < 8; k++) step(lvl, 1'b0);

    // Short random bursts never qualify on the LIMIT=4 instances
    for (int burst = 0; burst < 25; burst++) begin
      int len;
      int gap;
      len = int'($urandom_range(1, 3));
      gap = int'($urandom_range(1, 4));
      for (int j = 0; j < len + gap; j++) begin
        step((j < len) ? ~lvl : lvl, 1'b0);
        check("burst_a_deb",  ifa.o_Debounced, lvl);
        check("burst_a_rise", ifa.o_Rise,      1'b0);
        check("burst_a_fall", ifa.o_Fall,      1'b0);
        check("burst_c_deb",  ifc.o_Debounced, lvl);
      end
    end

    // Free-running random levels with random hold times and occasional resets
    for (int k = 0; k < 300; k++) begin
      int hold;
      bit b;
      hold = int'($urandom_range(1, 8));
      b    = bit'($urandom_range(0, 1));
      for (int h = 0; h < hold; h++)
        step(b, bit'($urandom_range(0, 99) == 0));
      if (e > 1900) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
